sram_responder: RTL and testbench
=================================

SRAM_RESPONDER -- requirements
Module: sram_responder

Interface
REQ-001 Parameter DEPTH, default 65536, number of 32-bit words implemented (power of two, 256..65536).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 sram_EN  input  1  access request from controller/DMA, sampled at rising edge.
REQ-005 sram_WE  input  1  1 = write, 0 = read; meaningful only when sram_EN=1.
REQ-006 sram_ADDR  input  16  word address.
REQ-007 sram_DI  input  32  write data.
REQ-008 sram_DO  output  32  registered read data.
REQ-009 load_valid  input  1  host preload request.
REQ-010 load_addr  input  16  host preload word address.
REQ-011 load_data  input  32  host preload data.
REQ-012 load_ready  output  1  host preload accepted this cycle when high together with load_valid.
REQ-013 fill_start  input  1  single-cycle pulse; starts a whole-memory fill.
REQ-014 fill_value  input  32  fill pattern, sampled on the fill_start edge.
REQ-015 fill_busy  output  1  fill engine active.
REQ-016 fill_done  output  1  single-cycle pulse after last fill write.
REQ-017 rd_count  output  32  accepted sram-port reads.
REQ-018 wr_count  output  32  accepted sram-port writes.
REQ-019 oob_err  output  1  sticky out-of-range access flag.

Function
REQ-020 Read: edge with sram_EN=1, sram_WE=0, in-range address A SHALL load sram_DO with mem[A]; value visible the cycle after the request (1-cycle latency).
REQ-021 sram_DO SHALL hold its value on all edges without an accepted sram-port read, including write cycles.
REQ-022 Write: edge with sram_EN=1, sram_WE=1, in-range A SHALL set mem[A]=sram_DI; a read of A on the next edge SHALL return the new data.
REQ-023 Address A >= DEPTH on sram port: write SHALL be discarded, read SHALL load sram_DO with 0, oob_err SHALL set to 1 and stay 1 until reset; counters still increment.
REQ-024 Priority per edge: sram port > fill engine > load port; exactly one memory write per edge at most.
REQ-025 load_ready SHALL be combinationally high iff sram_EN=0, fill_busy=0 and reset=0.
REQ-026 load_valid=1 and load_ready=1 SHALL write mem[load_addr]=load_data; out-of-range load_addr SHALL be discarded and SHALL set oob_err.
REQ-027 Fill FSM states IDLE, FILL; IDLE->FILL on fill_start=1, fill pointer cleared to 0, fill_value captured; fill_start in FILL ignored.
REQ-028 In FILL, each edge with sram_EN=0 SHALL write captured value to mem[ptr] and increment ptr; edges with sram_EN=1 stall the fill without advancing.
REQ-029 Write of ptr=DEPTH-1 SHALL transition FILL->IDLE and assert fill_done for exactly the following cycle; fill_busy=1 exactly while in FILL.
REQ-030 rd_count/wr_count SHALL increment by 1 per accepted sram-port read/write and saturate at 0xFFFFFFFF; fill and load writes not counted.

Reset
REQ-031 Reset edge SHALL set sram_DO=0, rd_count=0, wr_count=0, oob_err=0, fill_done=0, fill FSM=IDLE, fill pointer=0.
REQ-032 Memory contents SHALL NOT be cleared by reset; any sram, load or fill access presented on a reset edge SHALL be discarded.
REQ-033 Reset during FILL SHALL abort the fill without fill_done; words already written keep fill value.

Verification
REQ-034 Write 0x12345678 to addr 0x0010, read 0x0010 next edge -> sram_DO=0x12345678 one cycle after read, held through 3 idle cycles, wr_count=1, rd_count=1.
REQ-035 DEPTH=256: read addr 0x0100 -> sram_DO=0, oob_err=1; write 0xAAAA5555 to 0x0100 then read 0x0000 -> mem[0] unchanged; oob_err stays 1 until reset.
REQ-036 load_valid=1 with sram_EN=1 -> load_ready=0, no write; next cycle sram_EN=0 -> load accepted, read-back returns load_data.
REQ-037 DEPTH=256, fill_start with fill_value=0xCAFEF00D, sram reads injected on 10 cycles -> fill_done exactly 266 cycles after start, every word reads 0xCAFEF00D.
REQ-038 Reset asserted mid-fill at ptr=100 with sram write pending -> fill_busy=0, no fill_done, pending write discarded, counters 0, mem[0..99] hold fill value.
REQ-039 Force wr_count to 0xFFFFFFFE via 2^32-2 writes (or backdoor) then 3 writes -> wr_count=0xFFFFFFFF.

Source files
------------

// File: rtl/sram_responder.sv
// Single-port word SRAM with a controller port, a host preload port and a
// whole-memory fill engine sharing one write port. Registered read data.
module sram_responder #(
    parameter int DEPTH = 65536
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sram_EN,
    input  logic        sram_WE,
    input  logic [15:0] sram_ADDR,
    input  logic [31:0] sram_DI,
    output logic [31:0] sram_DO,
    input  logic        load_valid,
    input  logic [15:0] load_addr,
    input  logic [31:0] load_data,
    output logic        load_ready,
    input  logic        fill_start,
    input  logic [31:0] fill_value,
    output logic        fill_busy,
    output logic        fill_done,
    output logic [31:0] rd_count,
    output logic [31:0] wr_count,
    output logic        oob_err
);

    localparam int              AW        = $clog2(DEPTH);
    localparam logic [16:0]     DEPTH_EXT = 17'(DEPTH);
    localparam logic [AW-1:0]   LAST_PTR  = AW'(DEPTH - 1);
    localparam logic [31:0]     CNT_MAX   = 32'hFFFF_FFFF;

    typedef enum logic {
        S_IDLE,
        S_FILL
    } fill_state_t;

    logic [31:0]  mem [DEPTH];

    fill_state_t  state_reg, state_next;
    logic [AW-1:0] ptr_reg, ptr_next;
    logic [31:0]  fill_val_reg, fill_val_next;
    logic         fill_done_reg, fill_done_next;
    logic [31:0]  do_reg;
    logic [31:0]  rd_count_reg, rd_count_next;
    logic [31:0]  wr_count_reg, wr_count_next;
    logic         oob_reg, oob_next;

    logic          sram_in_range;
    logic          load_in_range;
    logic          sram_rd;
    logic          sram_wr;
    logic          fill_wr;
    logic          load_acc;
    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [31:0]   mem_wdata;

    // Everything is gated by reset so that nothing presented on a reset edge
    // touches the array or the counters.
    assign sram_in_range = ({1'b0, sram_ADDR} < DEPTH_EXT);
    assign load_in_range = ({1'b0, load_addr} < DEPTH_EXT);
    assign sram_rd       = sram_EN && !sram_WE && !reset;
    assign sram_wr       = sram_EN &&  sram_WE && !reset;
    assign fill_wr       = (state_reg == S_FILL) && !sram_EN && !reset;
    assign load_ready    = !sram_EN && !fill_busy && !reset;
    assign load_acc      = load_valid && load_ready;

    // Single write port: sram port wins, then fill, then preload.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = '0;
        mem_wdata = '0;
        if (sram_wr) begin
            mem_we    = sram_in_range;
            mem_waddr = sram_ADDR[AW-1:0];
            mem_wdata = sram_DI;
        end else if (fill_wr) begin
            mem_we    = 1'b1;
            mem_waddr = ptr_reg;
            mem_wdata = fill_val_reg;
        end else if (load_acc) begin
            mem_we    = load_in_range;
            mem_waddr = load_addr[AW-1:0];
            mem_wdata = load_data;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            do_reg <= '0;
        end else if (sram_rd) begin
            do_reg <= sram_in_range ? mem[sram_ADDR[AW-1:0]] : '0;
        end
    end

    always_comb begin
        state_next     = state_reg;
        ptr_next       = ptr_reg;
        fill_val_next  = fill_val_reg;
        fill_done_next = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (fill_start) begin
                    state_next    = S_FILL;
                    ptr_next      = '0;
                    fill_val_next = fill_value;
                end
            end
            S_FILL: begin
                // A busy sram port stalls the fill in place.
                if (!sram_EN) begin
                    ptr_next = ptr_reg + AW'(1);
                    if (ptr_reg == LAST_PTR) begin
                        state_next     = S_IDLE;
                        fill_done_next = 1'b1;
                    end
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        rd_count_next = rd_count_reg;
        wr_count_next = wr_count_reg;
        oob_next      = oob_reg;
        if (sram_rd && rd_count_reg != CNT_MAX) begin
            rd_count_next = rd_count_reg + 32'd1;
        end
        if (sram_wr && wr_count_reg != CNT_MAX) begin
            wr_count_next = wr_count_reg + 32'd1;
        end
        if ((sram_EN && !sram_in_range) || (load_acc && !load_in_range)) begin
            oob_next = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= S_IDLE;
            ptr_reg       <= '0;
            fill_val_reg  <= '0;
            fill_done_reg <= 1'b0;
            rd_count_reg  <= '0;
            wr_count_reg  <= '0;
            oob_reg       <= 1'b0;
        end else begin
            state_reg     <= state_next;
            ptr_reg       <= ptr_next;
            fill_val_reg  <= fill_val_next;
            fill_done_reg <= fill_done_next;
            rd_count_reg  <= rd_count_next;
            wr_count_reg  <= wr_count_next;
            oob_reg       <= oob_next;
        end
    end

    assign sram_DO   = do_reg;
    assign fill_busy = (state_reg == S_FILL);
    assign fill_done = fill_done_reg;
    assign rd_count  = rd_count_reg;
    assign wr_count  = wr_count_reg;
    assign oob_err   = oob_reg;

endmodule

// File: tb/tb_sram_responder.sv
// Randomised self-checking bench for sram_responder (DEPTH=256) against a
// word-array model of the memory, counters and sticky error flag.
module tb_sram_responder;

    localparam int DEPTH = 256;

    logic        clk = 1'b0;
    logic        reset;
    logic        sram_EN, sram_WE;
    logic [15:0] sram_ADDR;
    logic [31:0] sram_DI;
    logic [31:0] sram_DO;
    logic        load_valid;
    logic [15:0] load_addr;
    logic [31:0] load_data;
    logic        load_ready;
    logic        fill_start;
    logic [31:0] fill_value;
    logic        fill_busy, fill_done;
    logic [31:0] rd_count, wr_count;
    logic        oob_err;

    int errors = 0;
    int checks = 0;

    logic [31:0] m_mem [DEPTH];
    logic [31:0] m_do;
    logic [31:0] m_rd, m_wr;
    logic        m_oob;

    sram_responder #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .sram_EN(sram_EN), .sram_WE(sram_WE), .sram_ADDR(sram_ADDR),
        .sram_DI(sram_DI), .sram_DO(sram_DO),
        .load_valid(load_valid), .load_addr(load_addr), .load_data(load_data),
        .load_ready(load_ready),
        .fill_start(fill_start), .fill_value(fill_value),
        .fill_busy(fill_busy), .fill_done(fill_done),
        .rd_count(rd_count), .wr_count(wr_count), .oob_err(oob_err)
    );

    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic void model_reset();
        m_do  = 32'h0;
        m_rd  = 32'h0;
        m_wr  = 32'h0;
        m_oob = 1'b0;
    endfunction

    // One rising edge of the sram and preload ports, as the rules describe them.
    function automatic void model_edge(bit en, bit we, logic [15:0] addr, logic [31:0] di,
                                       bit lv, logic [15:0] la, logic [31:0] ld, bit fbusy);
        if (en) begin
            if (addr >= DEPTH) m_oob = 1'b1;
            if (we) begin
                if (addr < DEPTH) m_mem[addr[7:0]] = di;
                if (m_wr != 32'hFFFF_FFFF) m_wr = m_wr + 1;
            end else begin
                m_do = (addr < DEPTH) ? m_mem[addr[7:0]] : 32'h0;
                if (m_rd != 32'hFFFF_FFFF) m_rd = m_rd + 1;
            end
        end else if (!fbusy && lv) begin
            if (la < DEPTH) m_mem[la[7:0]] = ld;
            else m_oob = 1'b1;
        end
    endfunction

    task automatic idle_inputs();
        sram_EN = 0; sram_WE = 0; sram_ADDR = 0; sram_DI = 0;
        load_valid = 0; load_addr = 0; load_data = 0;
        fill_start = 0; fill_value = 0;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clk_edge();
        @(posedge clk);
        if (!reset) model_edge(sram_EN, sram_WE, sram_ADDR, sram_DI,
                               load_valid, load_addr, load_data, 1'b0);
        @(negedge clk);
    endtask

    task automatic sram_cycle(input bit we, input logic [15:0] addr, input logic [31:0] di);
        sram_EN = 1; sram_WE = we; sram_ADDR = addr; sram_DI = di; load_valid = 0;
        clk_edge();
        sram_EN = 0; sram_WE = 0;
    endtask

    task automatic do_reset();
        reset = 1;
        step();
        reset = 0;
        model_reset();
    endtask

    task automatic test_reset();
        reset = 1;
        sram_EN = 1; sram_WE = 1; sram_ADDR = 16'h0005; sram_DI = 32'h1;
        fill_start = 1; fill_value = 32'h77; load_valid = 1;
        #1;
        checks++;
        if (load_ready !== 1'b0) begin errors++; $display("FAIL reset_load_ready: got %b expected 0", load_ready); end
        step(); step();
        checks++;
        if (sram_DO !== 32'h0 || rd_count !== 32'h0 || wr_count !== 32'h0) begin
            errors++;
            $display("FAIL reset_regs: DO=%h rd=%h wr=%h expected all 0", sram_DO, rd_count, wr_count);
        end
        checks++;
        if ({oob_err, fill_busy, fill_done} !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags: oob/busy/done=%b expected 000", {oob_err, fill_busy, fill_done});
        end
        idle_inputs();
        reset = 0;
        model_reset();
    endtask

    task automatic test_fill();
        int done_at = -1;
        int injected = 0;
        logic [15:0] a;
        idle_inputs();
        fill_value = 32'hCAFE_F00D; fill_start = 1;
        step();
        fill_start = 0;
        checks++;
        if (fill_busy !== 1'b1) begin errors++; $display("FAIL fill_busy_start: got %b expected 1", fill_busy); end
        for (int n = 1; n <= 400; n++) begin
            sram_EN = 0; fill_start = 0;
            if (n % 20 == 3 && injected < 10) begin
                sram_EN = 1; sram_WE = 0; sram_ADDR = 16'($urandom_range(0, DEPTH - 1));
                injected++;
                m_rd = m_rd + 1;
            end
            if (n == 50) begin fill_start = 1; fill_value = 32'h0; end
            step();
            if (fill_done === 1'b1) begin done_at = n; break; end
        end
        idle_inputs();
        checks++;
        if (done_at != 266) begin errors++; $display("FAIL fill_done_cycle: got %0d expected 266", done_at); end
        checks++;
        if (fill_busy !== 1'b0) begin errors++; $display("FAIL fill_busy_end: got %b expected 0", fill_busy); end
        step();
        checks++;
        if (fill_done !== 1'b0) begin errors++; $display("FAIL fill_done_pulse: got %b expected 0", fill_done); end
        for (int i = 0; i < DEPTH; i++) m_mem[i] = 32'hCAFE_F00D;
        for (int i = 0; i < DEPTH; i++) begin
            a = 16'(i);
            sram_cycle(1'b0, a, 32'h0);
            checks++;
            if (sram_DO !== m_do) begin errors++; $display("FAIL fill_word[%0d]: got %h expected %h", i, sram_DO, m_do); end
        end
        checks++;
        if (rd_count !== m_rd) begin errors++; $display("FAIL fill_rd_count: got %0d expected %0d", rd_count, m_rd); end
    endtask

    task automatic test_basic();
        do_reset();
        sram_cycle(1'b1, 16'h0010, 32'h1234_5678);
        sram_cycle(1'b0, 16'h0010, 32'h0);
        checks++;
        if (sram_DO !== 32'h1234_5678) begin errors++; $display("FAIL basic_read: got %h expected 12345678", sram_DO); end
        for (int i = 0; i < 3; i++) begin
            clk_edge();
            checks++;
            if (sram_DO !== 32'h1234_5678) begin errors++; $display("FAIL basic_hold%0d: got %h expected 12345678", i, sram_DO); end
        end
        checks++;
        if (wr_count !== 32'd1 || rd_count !== 32'd1) begin
            errors++; $display("FAIL basic_counts: wr=%0d rd=%0d expected 1 1", wr_count, rd_count);
        end
    endtask

    task automatic test_oob();
        do_reset();
        sram_cycle(1'b0, 16'h0010, 32'h0);
        sram_cycle(1'b0, 16'h0100, 32'h0);
        checks++;
        if (sram_DO !== 32'h0 || oob_err !== 1'b1) begin
            errors++; $display("FAIL oob_read: DO=%h oob=%b expected 0 1", sram_DO, oob_err);
        end
        sram_cycle(1'b1, 16'h0100, 32'hAAAA_5555);
        sram_cycle(1'b0, 16'h0000, 32'h0);
        checks++;
        if (sram_DO !== m_do) begin errors++; $display("FAIL oob_alias: got %h expected %h", sram_DO, m_do); end
        for (int i = 0; i < 3; i++) clk_edge();
        checks++;
        if (oob_err !== 1'b1 || wr_count !== 32'd1 || rd_count !== 32'd3) begin
            errors++; $display("FAIL oob_sticky: oob=%b wr=%0d rd=%0d expected 1 1 3", oob_err, wr_count, rd_count);
        end
        do_reset();
        checks++;
        if (oob_err !== 1'b0) begin errors++; $display("FAIL oob_clear: got %b expected 0", oob_err); end
    endtask

    task automatic test_load();
        sram_EN = 1; sram_WE = 0; sram_ADDR = 16'h0020;
        load_valid = 1; load_addr = 16'h0030; load_data = 32'hDEAD_BEEF;
        #1;
        checks++;
        if (load_ready !== 1'b0) begin errors++; $display("FAIL load_blocked: got %b expected 0", load_ready); end
        clk_edge();
        sram_EN = 0;
        #1;
        checks++;
        if (load_ready !== 1'b1) begin errors++; $display("FAIL load_ready: got %b expected 1", load_ready); end
        clk_edge();
        load_valid = 0;
        sram_cycle(1'b0, 16'h0030, 32'h0);
        checks++;
        if (sram_DO !== 32'hDEAD_BEEF) begin errors++; $display("FAIL load_readback: got %h expected deadbeef", sram_DO); end
        load_valid = 1; load_addr = 16'h01FF; load_data = 32'h1;
        clk_edge();
        load_valid = 0;
        checks++;
        if (oob_err !== 1'b1) begin errors++; $display("FAIL load_oob: got %b expected 1", oob_err); end
        do_reset();
    endtask

    task automatic test_random();
        for (int n = 0; n < 300; n++) begin
            if (n == 150) do_reset();
            sram_EN    = ($urandom_range(0, 2) != 0);
            sram_WE    = 1'($urandom_range(0, 1));
            sram_ADDR  = 16'($urandom_range(0, 290));
            sram_DI    = $urandom;
            load_valid = 1'($urandom_range(0, 1));
            load_addr  = 16'($urandom_range(0, 270));
            load_data  = $urandom;
            #1;
            checks++;
            if (load_ready !== !sram_EN) begin errors++; $display("FAIL rnd_ready[%0d]: got %b expected %b", n, load_ready, !sram_EN); end
            clk_edge();
            checks++;
            if (sram_DO !== m_do || rd_count !== m_rd || wr_count !== m_wr || oob_err !== m_oob) begin
                errors++;
                $display("FAIL rnd_state[%0d]: DO=%h rd=%0d wr=%0d oob=%b expected %h %0d %0d %b",
                         n, sram_DO, rd_count, wr_count, oob_err, m_do, m_rd, m_wr, m_oob);
            end
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid_fill();
        bit seen_done = 0;
        do_reset();
        fill_value = 32'h5A5A_0001; fill_start = 1;
        step();
        fill_start = 0;
        for (int i = 0; i < 100; i++) step();
        reset = 1;
        sram_EN = 1; sram_WE = 1; sram_ADDR = 16'd200; sram_DI = 32'h1111_1111;
        step();
        reset = 0;
        idle_inputs();
        model_reset();
        checks++;
        if (fill_busy !== 1'b0 || sram_DO !== 32'h0 || rd_count !== 32'h0 || wr_count !== 32'h0) begin
            errors++;
            $display("FAIL midfill_reset: busy=%b DO=%h rd=%0d wr=%0d expected 0 0 0 0", fill_busy, sram_DO, rd_count, wr_count);
        end
        for (int i = 0; i < 300; i++) begin
            step();
            if (fill_done === 1'b1 || fill_busy === 1'b1) seen_done = 1;
        end
        checks++;
        if (seen_done) begin errors++; $display("FAIL midfill_no_done: got fill activity expected none"); end
        for (int i = 0; i < 100; i++) m_mem[i] = 32'h5A5A_0001;
        for (int i = 0; i < 102; i++) begin
            sram_cycle(1'b0, 16'(i), 32'h0);
            checks++;
            if (sram_DO !== m_do) begin errors++; $display("FAIL midfill_word[%0d]: got %h expected %h", i, sram_DO, m_do); end
        end
        sram_cycle(1'b0, 16'd200, 32'h0);
        checks++;
        if (sram_DO !== m_do) begin errors++; $display("FAIL midfill_discard: got %h expected %h", sram_DO, m_do); end
    endtask

    task automatic test_saturation();
        do_reset();
        force dut.wr_count_reg = 32'hFFFF_FFFE;
        step();
        release dut.wr_count_reg;
        m_wr = 32'hFFFF_FFFE;
        for (int i = 0; i < 3; i++) begin
            sram_cycle(1'b1, 16'($urandom_range(0, DEPTH - 1)), $urandom);
            checks++;
            if (wr_count !== 32'hFFFF_FFFF) begin errors++; $display("FAIL wr_saturate%0d: got %h expected ffffffff", i, wr_count); end
        end
        checks++;
        if (rd_count !== 32'h0) begin errors++; $display("FAIL sat_rd_count: got %h expected 0", rd_count); end
    endtask

    initial begin
        reset = 1;
        idle_inputs();
        model_reset();
        @(negedge clk);
        test_reset();
        test_fill();
        test_basic();
        test_oob();
        test_load();
        test_random();
        test_reset_mid_fill();
        test_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
